router_ctrl: RTL

Packet-level controller for the 1x3 router input path. It decodes the header address and sequences the header/payload/parity register stage through load, full-stall and parity-check phases. It drives the stage's control strobes and busy flag back to the source, and generates one-hot FIFO write enables plus the selected-FIFO full flag. It sits between the source interface, the input register stage and the three output FIFOs.

---
 rtl/router_pkg.sv | 27 ++
 rtl/router_if.sv | 36 +++
 rtl/router_ctrl.sv | 80 ++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router input-path controller.
package router_pkg;

    localparam int NUM_PORTS = 3;
    localparam int ADDR_W    = 2;
    localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'b11;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_e;

    // The invalid address selects no FIFO.
    function automatic logic [NUM_PORTS-1:0] onehot(input logic [ADDR_W-1:0] a);
        logic [NUM_PORTS-1:0] r;
        r = '0;
        if (a != INVALID_ADDR) r[a] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/router_if.sv
// Source/register-stage/FIFO signal bundle seen by the router controller.
interface router_if;
    import router_pkg::*;

    logic                 pkt_valid;
    logic [ADDR_W-1:0]    data_in;
    logic [NUM_PORTS-1:0] fifo_full;
    logic [NUM_PORTS-1:0] fifo_empty;
    logic [NUM_PORTS-1:0] soft_reset;
    logic                 parity_done;
    logic                 low_pkt_valid;

    logic                 detect_add;
    logic                 lfd_state;
    logic                 ld_state;
    logic                 laf_state;
    logic                 full_state;
    logic                 rst_int_reg;
    logic                 write_enb_reg;
    logic                 busy;
    logic [NUM_PORTS-1:0] write_enb;
    logic                 fifo_full_sel;

    modport master (
        output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset, parity_done, low_pkt_valid,
        input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
               write_enb_reg, busy, write_enb, fifo_full_sel
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset, parity_done, low_pkt_valid,
        output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
               write_enb_reg, busy, write_enb, fifo_full_sel
    );

endinterface

// File: rtl/router_ctrl.sv
// Packet sequencing FSM for the router input path: address latch, stage strobes,
// busy back-pressure and one-hot FIFO write enables.
module router_ctrl
    import router_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    router_if.slave  bus
);

    state_e            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic              addr_ld;

    // Guarded per-port select so the invalid address never indexes past the vector.
    function automatic logic pick(input logic [NUM_PORTS-1:0] v, input logic [ADDR_W-1:0] a);
        return (a == INVALID_ADDR) ? 1'b0 : v[a];
    endfunction

    assign addr_ld = (state == DECODE_ADDRESS) && bus.pkt_valid && (bus.data_in != INVALID_ADDR);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= DECODE_ADDRESS;
            addr_q <= '0;
        end else begin
            state <= state_nxt;
            if (addr_ld) addr_q <= bus.data_in;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state != DECODE_ADDRESS && pick(bus.soft_reset, addr_q)) begin
            state_nxt = DECODE_ADDRESS;
        end else begin
            case (state)
                DECODE_ADDRESS: begin
                    if (addr_ld)
                        state_nxt = pick(bus.fifo_empty, bus.data_in) ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
                WAIT_TILL_EMPTY: begin
                    if (pick(bus.fifo_empty, addr_q)) state_nxt = LOAD_FIRST_DATA;
                end
                LOAD_FIRST_DATA: state_nxt = LOAD_DATA;
                LOAD_DATA: begin
                    // A full FIFO wins over the parity byte; it is picked up after the stall.
                    if (pick(bus.fifo_full, addr_q)) state_nxt = FIFO_FULL_STATE;
                    else if (!bus.pkt_valid)         state_nxt = LOAD_PARITY;
                end
                FIFO_FULL_STATE: begin
                    if (!pick(bus.fifo_full, addr_q)) state_nxt = LOAD_AFTER_FULL;
                end
                LOAD_AFTER_FULL: begin
                    if (bus.parity_done)        state_nxt = DECODE_ADDRESS;
                    else if (bus.low_pkt_valid) state_nxt = LOAD_PARITY;
                    else                        state_nxt = LOAD_DATA;
                end
                LOAD_PARITY: state_nxt = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    state_nxt = pick(bus.fifo_full, addr_q) ? FIFO_FULL_STATE : DECODE_ADDRESS;
                end
                default: state_nxt = DECODE_ADDRESS;
            endcase
        end
    end

    assign bus.detect_add    = (state == DECODE_ADDRESS);
    assign bus.lfd_state     = (state == LOAD_FIRST_DATA);
    assign bus.ld_state      = (state == LOAD_DATA);
    assign bus.laf_state     = (state == LOAD_AFTER_FULL);
    assign bus.full_state    = (state == FIFO_FULL_STATE);
    assign bus.rst_int_reg   = (state == CHECK_PARITY_ERROR);
    assign bus.write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                               (state == LOAD_AFTER_FULL);
    assign bus.busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));
    assign bus.write_enb     = bus.write_enb_reg ? onehot(addr_q) : '0;
    assign bus.fifo_full_sel = pick(bus.fifo_full, addr_q);

endmodule
